// File: rtl/ifft_twid_sched.sv
// ---------------------------------------------------------------------------
// ifft_twid_sched
//
// Butterfly command scheduler for a 32-point radix-2 decimation-in-time IFFT.
// It walks 5 stages of 16 butterflies each, stage-major. For every butterfly
// it presents the two operand indices and the twiddle ROM index (positive
// angle 2*pi*k/32, so cos and sin use the same index) on a valid/ready
// handshake.
//
// Optional feature: define IFFT_STAGE_GAP_EN to insert GAP_CYCLES idle
// cycles (bf_valid low, busy high) between consecutive stages. Without the
// macro there is no gap state and no gap counter, and stages run
// back-to-back.
//
// Parameters
//   GAP_CYCLES  idle cycles between stages when IFFT_STAGE_GAP_EN (1..7)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle request to run one schedule (ignored when busy)
//   abort     in   cancel a running schedule at the next edge, no done pulse
//   busy      out  high from the accepted start until done or abort
//   done      out  one-cycle pulse after the last butterfly is accepted
//   bf_valid  out  butterfly command valid
//   bf_ready  in   datapath accepts the command
//   addr_a    out  upper operand index
//   addr_b    out  lower operand index (addr_a + 2^stage)
//   cos_ang   out  twiddle ROM cosine index
//   sin_ang   out  twiddle ROM sine index
//   stage     out  current stage 0..4
//   last_bf   out  high with the final butterfly of a stage
// ---------------------------------------------------------------------------
module ifft_twid_sched #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       bf_valid,
  input  logic       bf_ready,
  output logic [4:0] addr_a,
  output logic [4:0] addr_b,
  output logic [3:0] cos_ang,
  output logic [3:0] sin_ang,
  output logic [2:0] stage,
  output logic       last_bf
);

  // Elaboration-time guard on the gap length; the counter is 3 bits wide.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 7) begin : g_gap_range
    $error("ifft_twid_sched: GAP_CYCLES must be in 1..7");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
`ifdef IFFT_STAGE_GAP_EN
    ST_GAP,
`endif
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] k;
  } bf_cmd_t;

  // Operand/twiddle indices of butterfly j in stage s.
  //   pos = j mod 2^s, grp = j >> s
  //   a = grp*2^(s+1) + pos, b = a + 2^s, k = pos*2^(4-s)
  // pos < 2^s, so pos << (4-s) always fits in 4 bits.
  function automatic bf_cmd_t bf_calc(input logic [2:0] s, input logic [3:0] j);
    bf_cmd_t    r;
    logic [4:0] mask;
    logic [4:0] pos;
    logic [4:0] grp;
    mask = 5'((5'd1 << s) - 5'd1);
    pos  = {1'b0, j} & mask;
    grp  = {1'b0, j} >> s;
    r.a  = 5'(grp << (s + 3'd1)) + pos;
    r.b  = r.a + 5'(5'd1 << s);
    r.k  = 4'(pos << (3'd4 - s));
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [3:0] j_q, j_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic [4:0] addr_a_q, addr_b_q;
  logic [3:0] ang_q;
  bf_cmd_t    cmd_d;
  logic       xfer;
`ifdef IFFT_STAGE_GAP_EN
  localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES - 1);
  logic [2:0] gap_cnt_q, gap_cnt_d;
`endif

  assign xfer = valid_q & bf_ready;

  // Next-state logic. The command fields are always derived from the next
  // (s, j); holding s/j during a stall therefore holds every field, and
  // returning s/j to 0 reproduces the reset values (a=0, b=1, k=0).
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef IFFT_STAGE_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // start together with abort is treated as no request.
        if (start && !abort) begin
          state_d = ST_RUN;
          s_d     = 3'd0;
          j_d     = 4'd0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
        end
      end

      ST_RUN: begin
        // abort wins over a transfer happening in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
          s_d     = 3'd0;
          j_d     = 4'd0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else if (xfer) begin
          if (j_q == 4'd15) begin
            j_d = 4'd0;
            if (s_q == 3'd4) begin
              state_d = ST_DONE;
              s_d     = 3'd0;
              busy_d  = 1'b0;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              s_d = s_q + 3'd1;
`ifdef IFFT_STAGE_GAP_EN
              state_d   = ST_GAP;
              valid_d   = 1'b0;
              gap_cnt_d = GAP_LOAD;
`endif
            end
          end else begin
            j_d = j_q + 4'd1;
          end
        end
      end

`ifdef IFFT_STAGE_GAP_EN
      ST_GAP: begin
        // s/j already point at the first butterfly of the next stage.
        if (abort) begin
          state_d   = ST_IDLE;
          s_d       = 3'd0;
          j_d       = 4'd0;
          busy_d    = 1'b0;
          valid_d   = 1'b0;
          gap_cnt_d = 3'd0;
        end else if (gap_cnt_q == 3'd0) begin
          state_d = ST_RUN;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 3'd1;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = 3'd0;
        j_d     = 4'd0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    cmd_d  = bf_calc(s_d, j_d);
    last_d = valid_d && (j_d == 4'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      s_q      <= 3'd0;
      j_q      <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      addr_a_q <= 5'd0;
      addr_b_q <= 5'd1;
      ang_q    <= 4'd0;
`ifdef IFFT_STAGE_GAP_EN
      gap_cnt_q <= 3'd0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      j_q      <= j_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      addr_a_q <= cmd_d.a;
      addr_b_q <= cmd_d.b;
      ang_q    <= cmd_d.k;
`ifdef IFFT_STAGE_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bf_valid = valid_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign cos_ang  = ang_q;
  assign sin_ang  = ang_q;
  assign stage    = s_q;
  assign last_bf  = last_q;

endmodule

// File: tb/tb_ifft_twid_sched.sv
// ---------------------------------------------------------------------------
// tb_ifft_twid_sched
//
// Self-checking bench for ifft_twid_sched. The expected butterfly sequence
// is built by enumerating groups and positions of each DIT stage and
// deriving the twiddle from the angle 2*pi*pos/2^(s+1) = 2*pi*k/32.
// Works with or without IFFT_STAGE_GAP_EN defined.
// ---------------------------------------------------------------------------
module tb_ifft_twid_sched;

  localparam int GAP = 2;
`ifdef IFFT_STAGE_GAP_EN
  localparam int GAPS = 4 * GAP;
`else
  localparam int GAPS = 0;
`endif

  typedef logic [21:0] cmd_t;   // {stage, a, b, cos, sin, last}
  typedef logic [24:0] outv_t;  // {busy, done, valid, last, a, b, cos, sin, stage}

  localparam outv_t RESET_V = {4'b0000, 5'd0, 5'd1, 4'd0, 4'd0, 3'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       bf_ready = 1'b0;
  logic       busy, done, bf_valid, last_bf;
  logic [4:0] addr_a, addr_b;
  logic [3:0] cos_ang, sin_ang;
  logic [2:0] stage;

  ifft_twid_sched #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .bf_valid(bf_valid), .bf_ready(bf_ready),
    .addr_a(addr_a), .addr_b(addr_b), .cos_ang(cos_ang), .sin_ang(sin_ang),
    .stage(stage), .last_bf(last_bf)
  );

  always #5 clk = ~clk;

  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;
  cmd_t model_q[80];
  cmd_t log_a[80];
  cmd_t log_ref[80];

  function automatic cmd_t cur_cmd();
    return {stage, addr_a, addr_b, cos_ang, sin_ang, last_bf};
  endfunction

  function automatic outv_t cur_out();
    return {busy, done, bf_valid, last_bf, addr_a, addr_b, cos_ang, sin_ang, stage};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    int n = 0;
    for (int s = 0; s < 5; s++) begin
      int span = 1 << (s + 1);        // butterfly group span
      int half = 1 << s;              // distance between a and b
      for (int g = 0; g < 32 / span; g++) begin
        for (int p = 0; p < half; p++) begin
          int a = g * span + p;
          int k = (p * 32) / span;    // angle 2*pi*p/span == 2*pi*k/32
          bit last = (g == 32 / span - 1) && (p == half - 1);
          model_q[n] = {3'(s), 5'(a), 5'(a + half), 4'(k), 4'(k), last};
          n++;
        end
      end
    end
  endtask

  // Runs one schedule from a start pulse. abort_at >= 0 raises abort on the
  // cycle that would carry that (0-based) transfer.
  task automatic run_sched(input int ready_pct, input int abort_at, input bit poke_start,
                           output int n_xfer, output int done_cyc, output int busy_cyc,
                           output int gap_cyc, output bit gap_pos_ok, output int stall_bad);
    cmd_t prev = '0;
    bit   stalled = 1'b0;
    bit   fin = 1'b0;
    int   cyc = 0;
    n_xfer = 0; done_cyc = -1; busy_cyc = 0; gap_cyc = 0; gap_pos_ok = 1'b1; stall_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 1000) begin
      cyc++;
      if (busy) busy_cyc++;
      if (busy && !bf_valid) begin
        gap_cyc++;
        if (!(n_xfer inside {16, 32, 48, 64})) gap_pos_ok = 1'b0;
      end
      if (stalled && (!bf_valid || cur_cmd() !== prev)) stall_bad++;
      if (done) begin done_cyc = cyc; fin = 1'b1; end
      bf_ready = ($urandom_range(0, 99) < ready_pct);
      start = poke_start && (busy || done) && ($urandom_range(0, 3) == 0);
      if (bf_valid && bf_ready && abort_at == n_xfer) begin
        abort = 1'b1;
        fin = 1'b1;
      end else if (bf_valid && bf_ready) begin
        if (n_xfer < 80) log_a[n_xfer] = cur_cmd();
        n_xfer++;
      end
      stalled = bf_valid && !bf_ready;
      prev = cur_cmd();
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
    end
    bf_ready = 1'b0;
    $display("run ready=%0d%% abort_at=%0d: xfers=%0d done_cyc=%0d busy_cyc=%0d gap_cyc=%0d",
             ready_pct, abort_at, n_xfer, done_cyc, busy_cyc, gap_cyc);
  endtask

  initial begin
    int n, dc, bc, gc, sb, diff, dones;
    bit gok, found;

    build_model();

    // Reset state
    #12;
    chk("reset_outputs", cur_out(), RESET_V);
    @(negedge clk); rst_n = 1'b1;

    // start together with abort in IDLE: stay idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("idle_start_abort_busy", busy, 1'b0);
    chk("idle_start_abort_valid", bf_valid, 1'b0);

    // Full-throughput run
    run_sched(100, -1, 1'b0, n, dc, bc, gc, gok, sb);
    chk("run1_xfers", n, 80);
    chk("run1_done_cycle", dc, 81 + GAPS);
    chk("run1_busy_cycles", bc, 80 + GAPS);
    chk("run1_gap_cycles", gc, GAPS);
    chk("run1_gap_position", gok, 1'b1);
    chk("run1_done_one_cycle", done, 1'b0);
    chk("run1_idle_after", busy, 1'b0);
    for (int i = 0; i < 80; i++) begin
      chk($sformatf("run1_seq[%0d]", i), log_a[i], model_q[i]);
      log_ref[i] = log_a[i];
    end
    chk("spot_s0_j0",  log_ref[0],  {3'd0, 5'd0,  5'd1,  4'd0,  4'd0,  1'b0});
    chk("spot_s2_j6",  log_ref[38], {3'd2, 5'd10, 5'd14, 4'd8,  4'd8,  1'b0});
    chk("spot_s4_j5",  log_ref[69], {3'd4, 5'd5,  5'd21, 4'd5,  4'd5,  1'b0});
    chk("spot_s3_j15", log_ref[63], {3'd3, 5'd23, 5'd31, 4'd14, 4'd14, 1'b1});

    // Random backpressure, stray start pulses while busy / in DONE
    run_sched(50, -1, 1'b1, n, dc, bc, gc, gok, sb);
    chk("run2_xfers", n, 80);
    chk("run2_done_seen", (dc > 0), 1'b1);
    chk("run2_stall_stable", sb, 0);
    chk("run2_gap_cycles", gc, GAPS);
    chk("run2_gap_position", gok, 1'b1);
    chk("run2_idle_after", busy, 1'b0);
    diff = 0;
    for (int i = 0; i < 80; i++) if (log_a[i] !== log_ref[i]) diff++;
    chk("run2_same_as_nostall", diff, 0);

    // Abort coincident with the 37th transfer
    run_sched(100, 36, 1'b0, n, dc, bc, gc, gok, sb);
    chk("abort_xfers", n, 36);
    chk("abort_no_done_in_run", dc, -1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", bf_valid, 1'b0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done_after", dones, 0);
    run_sched(100, -1, 1'b0, n, dc, bc, gc, gok, sb);
    chk("restart_first", log_a[0], model_q[0]);
    chk("restart_xfers", n, 80);

    // Reset while stalled in stage 3
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (stage == 3'd3 && bf_valid && addr_a != 5'd16) begin
        bf_ready = 1'b0;
        found = 1'b1;
      end else begin
        bf_ready = ($urandom_range(0, 1) == 1);
        @(negedge clk);
      end
    end
    chk("rst_stall_found", found, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs", cur_out(), RESET_V);
    @(negedge clk); rst_n = 1'b1;
    run_sched(100, -1, 1'b0, n, dc, bc, gc, gok, sb);
    chk("post_rst_first", log_a[0], model_q[0]);
    chk("post_rst_xfers", n, 80);
    chk("post_rst_done_cycle", dc, 81 + GAPS);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
